// File: rtl/tl_c_scope_capture.sv
// rtl/tl_c_scope_capture.sv - TileLink channel-C scope: circular trace capture, opcode trigger, oldest-first drain
// Optional per-record cycle timestamp: define TL_C_SCOPE_TIMESTAMP_EN.
module tl_c_scope_capture #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int SOURCE_W = 3,
    parameter int SIZE_W   = 4,
    parameter int DEPTH    = 16,
`ifdef TL_C_SCOPE_TIMESTAMP_EN
    parameter int TS_W     = 16,
    localparam int TSX     = TS_W,
`else
    localparam int TSX     = 0,
`endif
    localparam int AW      = $clog2(DEPTH),
    localparam int REC_W   = 7 + SIZE_W + SOURCE_W + ADDR_W + DATA_W + TSX
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                c_valid,
    input  logic                c_ready,
    input  logic [2:0]          c_opcode,
    input  logic [2:0]          c_param,
    input  logic [SIZE_W-1:0]   c_size,
    input  logic [SOURCE_W-1:0] c_source,
    input  logic [ADDR_W-1:0]   c_address,
    input  logic [DATA_W-1:0]   c_data,
    input  logic                c_corrupt,
    input  logic                arm,
    input  logic                disarm,
    input  logic [2:0]          trig_opcode,
    input  logic [2:0]          trig_mask,
    input  logic [AW-1:0]       post_count,
    output logic [1:0]          state,
    output logic                triggered,
    output logic                wrapped,
    output logic [AW:0]         level,
    output logic                rd_valid,
    input  logic                rd_ready,
    output logic [REC_W-1:0]    rd_data
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_POST  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    state_t           st;
    logic [REC_W-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    remain;
    logic [REC_W-1:0] rec;
    logic             fire;
    logic             hit;
    logic             capturing;
    logic             wr_en;
    logic             pop;

    assign fire      = c_valid & c_ready;
    assign hit       = fire & (((c_opcode ^ trig_opcode) & trig_mask) == 3'd0);
    assign capturing = (st == S_ARMED) || (st == S_POST);
    assign wr_en     = fire & capturing & ~disarm & ~reset;

    // Oldest entry sits level slots behind the write pointer; a full buffer wraps to wr_ptr itself.
    assign rd_ptr    = wr_ptr - level[AW-1:0];
    assign rd_valid  = (st == S_DONE) && (level != '0);
    assign pop       = rd_valid & rd_ready;
    assign rd_data   = rd_valid ? mem[rd_ptr] : '0;
    assign triggered = (st == S_ARMED) & hit & ~disarm & ~reset;
    assign state     = st;

`ifdef TL_C_SCOPE_TIMESTAMP_EN
    logic [TS_W-1:0] ts;

    always_ff @(posedge clock) begin
        if (reset) ts <= '0;
        else       ts <= ts + TS_W'(1);
    end

    assign rec = {c_opcode, c_param, c_size, c_source, c_address, c_data, c_corrupt, ts};
`else
    assign rec = {c_opcode, c_param, c_size, c_source, c_address, c_data, c_corrupt};
`endif

    always_ff @(posedge clock) begin
        if (wr_en) mem[wr_ptr] <= rec;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            st      <= S_IDLE;
            level   <= '0;
            wrapped <= 1'b0;
            wr_ptr  <= '0;
            remain  <= '0;
        end else if (disarm) begin
            st      <= S_IDLE;
            level   <= '0;
            wrapped <= 1'b0;
        end else begin
            case (st)
                S_IDLE: begin
                    if (arm) begin
                        st      <= S_ARMED;
                        level   <= '0;
                        wrapped <= 1'b0;
                        wr_ptr  <= '0;
                        remain  <= '0;
                    end
                end
                S_ARMED, S_POST: begin
                    if (fire) begin
                        wr_ptr <= wr_ptr + AW'(1);
                        if (level == FULL) wrapped <= 1'b1;
                        else               level   <= level + (AW+1)'(1);
                        if (st == S_ARMED) begin
                            if (hit) begin
                                if (post_count == '0) begin
                                    st <= S_DONE;
                                end else begin
                                    st     <= S_POST;
                                    remain <= post_count;
                                end
                            end
                        end else begin
                            remain <= remain - AW'(1);
                            if (remain == AW'(1)) st <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    if (pop) begin
                        level <= level - (AW+1)'(1);
                        if (level == (AW+1)'(1)) st <= S_IDLE;
                    end
                end
                default: st <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_tl_c_scope_capture.sv
// tb/tb_tl_c_scope_capture.sv - randomized self-checking bench for tl_c_scope_capture against a queue model
module tb_tl_c_scope_capture;
    localparam int ADDR_W   = 32;
    localparam int DATA_W   = 32;
    localparam int SOURCE_W = 3;
    localparam int SIZE_W   = 4;
    localparam int DEPTH    = 16;
    localparam int AW       = 4;
`ifdef TL_C_SCOPE_TIMESTAMP_EN
    localparam int TS_W     = 16;
    localparam int REC_W    = 7 + SIZE_W + SOURCE_W + ADDR_W + DATA_W + TS_W;
`else
    localparam int REC_W    = 7 + SIZE_W + SOURCE_W + ADDR_W + DATA_W;
`endif
    typedef logic [REC_W-1:0] rec_t;

    logic                clock = 1'b0;
    logic                reset = 1'b1;
    logic                c_valid = 1'b0;
    logic                c_ready = 1'b0;
    logic [2:0]          c_opcode = '0;
    logic [2:0]          c_param = '0;
    logic [SIZE_W-1:0]   c_size = '0;
    logic [SOURCE_W-1:0] c_source = '0;
    logic [ADDR_W-1:0]   c_address = '0;
    logic [DATA_W-1:0]   c_data = '0;
    logic                c_corrupt = 1'b0;
    logic                arm = 1'b0;
    logic                disarm = 1'b0;
    logic [2:0]          trig_opcode = '0;
    logic [2:0]          trig_mask = '0;
    logic [AW-1:0]       post_count = '0;
    logic [1:0]          state;
    logic                triggered;
    logic                wrapped;
    logic [AW:0]         level;
    logic                rd_valid;
    logic                rd_ready = 1'b0;
    rec_t                rd_data;

    always #5 clock = ~clock;

    tl_c_scope_capture dut (
        .clock(clock), .reset(reset),
        .c_valid(c_valid), .c_ready(c_ready), .c_opcode(c_opcode), .c_param(c_param),
        .c_size(c_size), .c_source(c_source), .c_address(c_address), .c_data(c_data),
        .c_corrupt(c_corrupt), .arm(arm), .disarm(disarm), .trig_opcode(trig_opcode),
        .trig_mask(trig_mask), .post_count(post_count), .state(state), .triggered(triggered),
        .wrapped(wrapped), .level(level), .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data)
    );

    int   checks = 0;
    int   errors = 0;
    rec_t mq[$];
    int   m_state = 0;
    logic m_wrapped = 1'b0;
    int   m_remain = 0;

`ifdef TL_C_SCOPE_TIMESTAMP_EN
    logic [TS_W-1:0] tb_ts = '0;
    always @(posedge clock) tb_ts <= reset ? '0 : tb_ts + TS_W'(1);
`endif

    // One snooped cycle; the model applies the capture/trigger rules at the queue level.
    task automatic beat(input logic v, input logic r, input logic [2:0] op,
                        output logic trig_obs, output logic trig_exp, output rec_t rec);
        rec_t d;
        c_valid = v; c_ready = r; c_opcode = op;
        c_param = 3'($urandom); c_size = SIZE_W'($urandom); c_source = SOURCE_W'($urandom);
        c_address = $urandom; c_data = $urandom; c_corrupt = 1'($urandom);
        @(negedge clock);
        trig_obs = triggered;
        trig_exp = 1'b0;
`ifdef TL_C_SCOPE_TIMESTAMP_EN
        rec = {c_opcode, c_param, c_size, c_source, c_address, c_data, c_corrupt, tb_ts};
`else
        rec = {c_opcode, c_param, c_size, c_source, c_address, c_data, c_corrupt};
`endif
        if (v && r && (m_state == 1 || m_state == 2)) begin
            mq.push_back(rec);
            if (mq.size() > DEPTH) begin
                d = mq.pop_front();
                m_wrapped = 1'b1;
            end
            if (m_state == 1) begin
                if (((op ^ trig_opcode) & trig_mask) == 3'd0) begin
                    trig_exp = 1'b1;
                    if (post_count == '0) m_state = 3;
                    else begin m_state = 2; m_remain = int'(post_count); end
                end
            end else begin
                m_remain--;
                if (m_remain == 0) m_state = 3;
            end
        end
        @(posedge clock); #1;
        c_valid = 1'b0; c_ready = 1'b0;
    endtask

    task automatic pop(input logic rdy, output logic v_obs, output rec_t d_obs,
                       output logic v_exp, output rec_t d_exp);
        rec_t d;
        rd_ready = rdy;
        @(negedge clock);
        v_obs = rd_valid; d_obs = rd_data;
        v_exp = (m_state == 3) && (mq.size() != 0);
        d_exp = v_exp ? mq[0] : '0;
        if (v_exp && rdy) begin
            d = mq.pop_front();
            if (mq.size() == 0) m_state = 0;
        end
        @(posedge clock); #1;
        rd_ready = 1'b0;
    endtask

    task automatic ctrl(input logic a, input logic d);
        arm = a; disarm = d;
        @(posedge clock); #1;
        if (d) begin
            m_state = 0; mq.delete(); m_wrapped = 1'b0;
        end else if (a && m_state == 0) begin
            m_state = 1; mq.delete(); m_wrapped = 1'b0;
        end
        arm = 1'b0; disarm = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; c_valid = 1'b1; c_ready = 1'b1; arm = 1'b1; rd_ready = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", state); end
        checks++; if (triggered !== 1'b0) begin errors++; $display("FAIL reset_triggered: got %b want 0", triggered); end
        checks++; if (wrapped !== 1'b0) begin errors++; $display("FAIL reset_wrapped: got %b want 0", wrapped); end
        checks++; if (level !== '0) begin errors++; $display("FAIL reset_level: got %0d want 0", level); end
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid: got %b want 0", rd_valid); end
        checks++; if (rd_data !== '0) begin errors++; $display("FAIL reset_rd_data: got %h want 0", rd_data); end
        @(posedge clock); #1;
        reset = 1'b0; c_valid = 1'b0; c_ready = 1'b0; arm = 1'b0; rd_ready = 1'b0;
        m_state = 0; mq.delete(); m_wrapped = 1'b0;
    endtask

    task automatic test_basic();
        logic to, te, vo, ve; rec_t r, dobs, dexp;
        logic [2:0] ops [8];
        ops = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd6, 3'd4};
        trig_opcode = 3'd4; trig_mask = 3'd7; post_count = 4'd2;
        ctrl(1'b1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            beat(1'b1, 1'b1, ops[i], to, te, r);
            checks++; if (to !== (i == 4)) begin errors++; $display("FAIL basic_trig[%0d]: got %b want %b", i, to, i == 4); end
            if (i == 6) begin
                checks++; if (state !== 2'd3) begin errors++; $display("FAIL basic_done: got %0d want 3", state); end
            end
        end
        checks++; if (level !== 5'd7) begin errors++; $display("FAIL basic_level: got %0d want 7", level); end
        checks++; if (wrapped !== 1'b0) begin errors++; $display("FAIL basic_wrapped: got %b want 0", wrapped); end
        for (int i = 0; i < 7; i++) begin
            pop(1'b1, vo, dobs, ve, dexp);
            checks++; if (vo !== 1'b1 || dobs !== dexp) begin errors++; $display("FAIL basic_drain[%0d]: got v=%b %h want v=1 %h", i, vo, dobs, dexp); end
            checks++; if (dobs[REC_W-1 -: 3] !== ops[i]) begin errors++; $display("FAIL basic_opcode[%0d]: got %0d want %0d", i, dobs[REC_W-1 -: 3], ops[i]); end
        end
        checks++; if (state !== 2'd0 || rd_valid !== 1'b0) begin errors++; $display("FAIL basic_idle: got state=%0d rd_valid=%b want 0/0", state, rd_valid); end
    endtask

    task automatic test_wrap();
        logic to, te, vo, ve; rec_t r, dobs, dexp;
        rec_t fires [21];
        logic [2:0] t;
        t = 3'($urandom); trig_opcode = t; trig_mask = 3'd7; post_count = '0;
        ctrl(1'b1, 1'b0);
        for (int i = 0; i < 21; i++) begin
            if ($urandom_range(0, 2) == 0) beat(1'b1, 1'b0, t, to, te, r);
            beat(1'b1, 1'b1, (i == 20) ? t : (t ^ 3'($urandom_range(1, 7))), to, te, fires[i]);
            checks++; if (to !== te) begin errors++; $display("FAIL wrap_trig[%0d]: got %b want %b", i, to, te); end
        end
        checks++; if (wrapped !== 1'b1) begin errors++; $display("FAIL wrap_wrapped: got %b want 1", wrapped); end
        checks++; if (level !== 5'd16 || state !== 2'd3) begin errors++; $display("FAIL wrap_level: got %0d/%0d want 16/3", level, state); end
        for (int i = 0; i < 16; i++) begin
            pop(1'b1, vo, dobs, ve, dexp);
            checks++; if (vo !== 1'b1 || dobs !== fires[i+5]) begin errors++; $display("FAIL wrap_drain[%0d]: got v=%b %h want v=1 %h", i, vo, dobs, fires[i+5]); end
        end
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL wrap_idle: got %0d want 0", state); end
    endtask

    task automatic test_backpressure();
        logic to, te, vo, ve; rec_t r, dobs, dexp, first;
        trig_opcode = 3'd0; trig_mask = 3'd0; post_count = 4'd3;
        ctrl(1'b1, 1'b0);
        for (int i = 0; i < 4; i++) beat(1'b1, 1'b1, 3'($urandom), to, te, r);
        first = mq[0];
        for (int i = 0; i < 4; i++) begin
            pop(1'b0, vo, dobs, ve, dexp);
            checks++; if (vo !== 1'b1 || dobs !== first) begin errors++; $display("FAIL bp_hold[%0d]: got v=%b %h want v=1 %h", i, vo, dobs, first); end
            checks++; if (level !== 5'd4) begin errors++; $display("FAIL bp_level[%0d]: got %0d want 4", i, level); end
        end
        for (int i = 0; i < 4; i++) begin
            pop(1'b1, vo, dobs, ve, dexp);
            checks++; if (vo !== ve || dobs !== dexp) begin errors++; $display("FAIL bp_drain[%0d]: got %h want %h", i, dobs, dexp); end
        end
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL bp_idle: got %0d want 0", state); end
    endtask

    task automatic test_no_ready();
        logic to, te; rec_t r;
        trig_opcode = 3'd2; trig_mask = 3'd7; post_count = '0;
        ctrl(1'b1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            beat(1'b1, 1'b0, 3'd2, to, te, r);
            checks++; if (to !== 1'b0) begin errors++; $display("FAIL noready_trig[%0d]: got %b want 0", i, to); end
        end
        checks++; if (level !== '0 || state !== 2'd1) begin errors++; $display("FAIL noready_level: got %0d/%0d want 0/1", level, state); end
        ctrl(1'b0, 1'b1);
    endtask

    task automatic test_arm_disarm();
        logic to, te; rec_t r;
        ctrl(1'b1, 1'b1);
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL armdis_same: got %0d want 0", state); end
        trig_opcode = 3'd6; trig_mask = 3'd7; post_count = 4'd10;
        ctrl(1'b1, 1'b0);
        beat(1'b1, 1'b1, 3'd6, to, te, r);
        for (int i = 0; i < 8; i++) beat(1'b1, 1'b1, 3'($urandom), to, te, r);
        ctrl(1'b1, 1'b0);
        checks++; if (level !== 5'd9 || state !== 2'd2) begin errors++; $display("FAIL armdis_post: got %0d/%0d want 9/2", level, state); end
        rd_ready = 1'b1;
        ctrl(1'b0, 1'b1);
        checks++; if (state !== 2'd0 || level !== '0 || rd_valid !== 1'b0 || wrapped !== 1'b0) begin
            errors++; $display("FAIL armdis_abort: got state=%0d level=%0d rd_valid=%b want 0/0/0", state, level, rd_valid);
        end
    endtask

    task automatic test_random();
        logic to, te, vo, ve; rec_t r, dobs, dexp;
        int n;
        for (int it = 0; it < 8; it++) begin
            trig_opcode = 3'($urandom); trig_mask = 3'($urandom); post_count = AW'($urandom);
            ctrl(1'b1, 1'b0);
            n = 0;
            while (m_state != 3 && n < 200) begin
                beat(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0), 3'($urandom), to, te, r);
                checks++; if (to !== te) begin errors++; $display("FAIL rand_trig[%0d.%0d]: got %b want %b", it, n, to, te); end
                n++;
            end
            if (m_state != 3) ctrl(1'b0, 1'b1);
            checks++; if (state !== 2'(m_state) || level !== (AW+1)'(mq.size()) || wrapped !== m_wrapped) begin
                errors++; $display("FAIL rand_status[%0d]: got %0d/%0d/%b want %0d/%0d/%b", it, state, level, wrapped, m_state, mq.size(), m_wrapped);
            end
            n = 0;
            while (m_state == 3 && n < 120) begin
                pop(1'($urandom), vo, dobs, ve, dexp);
                checks++; if (vo !== ve || (ve && dobs !== dexp)) begin errors++; $display("FAIL rand_drain[%0d.%0d]: got v=%b %h want v=%b %h", it, n, vo, dobs, ve, dexp); end
                n++;
            end
            checks++; if (m_state != 0 || state !== 2'd0) begin errors++; $display("FAIL rand_idle[%0d]: got %0d want 0", it, state); end
        end
    endtask

    task automatic test_reset_mid();
        logic to, te; rec_t r, dobs, dexp; logic vo, ve;
        trig_mask = 3'd0; post_count = 4'd3;
        ctrl(1'b1, 1'b0);
        for (int i = 0; i < 4; i++) beat(1'b1, 1'b1, 3'($urandom), to, te, r);
        pop(1'b1, vo, dobs, ve, dexp);
        reset = 1'b1; c_valid = 1'b1; c_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        checks++; if (state !== 2'd0 || level !== '0 || wrapped !== 1'b0 || rd_valid !== 1'b0 || rd_data !== '0 || triggered !== 1'b0) begin
            errors++; $display("FAIL midreset: got state=%0d level=%0d rd_valid=%b want all zero", state, level, rd_valid);
        end
        @(posedge clock); #1;
        reset = 1'b0; c_valid = 1'b0; c_ready = 1'b0;
        m_state = 0; mq.delete(); m_wrapped = 1'b0;
    endtask

`ifdef TL_C_SCOPE_TIMESTAMP_EN
    task automatic test_timestamp();
        logic to, te, vo, ve; rec_t r, dobs, dexp;
        logic [TS_W-1:0] prev;
        int n;
        n = 0;
        while (tb_ts != 16'hFFF0 && n < 70000) begin @(posedge clock); #1; n++; end
        checks++; if (n >= 70000) begin errors++; $display("FAIL ts_wait: timeout got %h want fff0", tb_ts); end
        trig_opcode = 3'd5; trig_mask = 3'd7; post_count = '0;
        ctrl(1'b1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            beat(1'b1, 1'b1, (i == 7) ? 3'd5 : 3'd1, to, te, r);
            beat(1'b0, 1'b0, 3'd0, to, te, r);
            beat(1'b0, 1'b0, 3'd0, to, te, r);
        end
        prev = '0;
        for (int i = 0; i < 8; i++) begin
            pop(1'b1, vo, dobs, ve, dexp);
            checks++; if (vo !== 1'b1 || dobs !== dexp) begin errors++; $display("FAIL ts_rec[%0d]: got %h want %h", i, dobs, dexp); end
            if (i > 0) begin
                checks++; if (TS_W'(dobs[TS_W-1:0] - prev) !== TS_W'(3)) begin errors++; $display("FAIL ts_delta[%0d]: got %h after %h want +3", i, dobs[TS_W-1:0], prev); end
            end
            prev = dobs[TS_W-1:0];
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_no_ready();
        test_arm_disarm();
        test_random();
        test_reset_mid();
`ifdef TL_C_SCOPE_TIMESTAMP_EN
        test_timestamp();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
